// File: rtl/lfsr32_checker.sv
// lfsr32_checker: locks onto a 32-bit Fibonacci LFSR stream (x^32 taps 31,1),
// then flags every word that deviates from the free-running prediction.
module lfsr32_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        clear_counts,
  output logic        locked,
  output logic        error,
  output logic [15:0] err_count,
  output logic [31:0] word_count,
  output logic        zero_seen
);

  typedef enum logic [1:0] {S_HUNT, S_ACQUIRE, S_LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);

  state_t      state, next_state;
  logic [31:0] ref_word, next_ref;
  logic [3:0]  match_cnt, next_match;
  logic [3:0]  miss_cnt, next_miss;
  logic [31:0] predicted;
  logic [3:0]  match_inc, miss_inc;
  logic        count_word, mispredict;

  // One generator step: shift left, feedback of bit31 xor bit1 into bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[1]};
  endfunction

  // Error counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign predicted = lfsr_next(ref_word);
  assign match_inc = match_cnt + 4'd1;
  assign miss_inc  = miss_cnt + 4'd1;

  // State register; reset abandons any lock immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_HUNT;
    else       state <= next_state;
  end

  // Next-state and tracking logic; nothing moves without a valid word.
  always_comb begin
    next_state = state;
    next_ref   = ref_word;
    next_match = match_cnt;
    next_miss  = miss_cnt;
    count_word = 1'b0;
    mispredict = 1'b0;
    if (in_valid) begin
      unique case (state)
        S_HUNT: begin
          if (in_data != 32'd0) begin
            next_ref   = in_data;
            next_match = 4'd0;
            next_state = S_ACQUIRE;
          end
        end
        S_ACQUIRE: begin
          if (in_data == predicted) begin
            next_ref   = in_data;
            next_match = match_inc;
            if (match_inc == LOCK_N) begin
              next_state = S_LOCKED;
              next_miss  = 4'd0;
            end
          end else begin
            next_match = 4'd0;
            if (in_data != 32'd0) next_ref = in_data;
            else                  next_state = S_HUNT;
          end
        end
        S_LOCKED: begin
          // Prediction free-wheels so corrupted input never poisons it.
          next_ref   = predicted;
          count_word = 1'b1;
          if (in_data != predicted) begin
            mispredict = 1'b1;
            next_miss  = miss_inc;
            if (miss_inc == LOSS_N) next_state = S_HUNT;
          end else begin
            next_miss = 4'd0;
          end
        end
        default: next_state = S_HUNT;
      endcase
    end
  end

  // Registered tracking state and outputs; clear_counts beats a counted word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ref_word   <= 32'd0;
      match_cnt  <= 4'd0;
      miss_cnt   <= 4'd0;
      locked     <= 1'b0;
      error      <= 1'b0;
      err_count  <= 16'd0;
      word_count <= 32'd0;
      zero_seen  <= 1'b0;
    end else begin
      ref_word  <= next_ref;
      match_cnt <= next_match;
      miss_cnt  <= next_miss;
      locked    <= (next_state == S_LOCKED);
      error     <= mispredict;
      if (in_valid && in_data == 32'd0) zero_seen <= 1'b1;
      if (clear_counts) begin
        err_count  <= 16'd0;
        word_count <= 32'd0;
      end else begin
        if (count_word) word_count <= word_count + 32'd1;
        if (mispredict) err_count  <= sat_inc16(err_count);
      end
    end
  end

endmodule

// File: tb/tb_lfsr32_checker.sv
// Randomized bench for lfsr32_checker with an in-bench behavioural model.
module tb_lfsr32_checker;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        clear_counts;
  logic        locked, error, zero_seen;
  logic [15:0] err_count;
  logic [31:0] word_count;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b0;

  lfsr32_checker dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .clear_counts(clear_counts), .locked(locked), .error(error),
    .err_count(err_count), .word_count(word_count), .zero_seen(zero_seen)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  localparam int HUNT = 0, ACQ = 1, LOCK = 2;
  localparam int LOCK_N = 4, LOSS_N = 3;
  int          m_mode;
  logic [31:0] m_ref;
  int          m_hits, m_misses;
  logic [15:0] m_ec;
  logic [31:0] m_wc;
  bit          m_err, m_zero;

  function automatic logic [31:0] nxt(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[1]};
  endfunction

  task automatic model_reset();
    m_mode = HUNT; m_ref = 0; m_hits = 0; m_misses = 0;
    m_ec = 0; m_wc = 0; m_err = 0; m_zero = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] d, input bit c);
    logic [31:0] expw;
    m_err = 0;
    if (v) begin
      if (d == 0) m_zero = 1;
      expw = nxt(m_ref);
      if (m_mode == HUNT) begin
        if (d != 0) begin m_ref = d; m_hits = 0; m_mode = ACQ; end
      end else if (m_mode == ACQ) begin
        if (d == expw) begin
          m_ref = d; m_hits++;
          if (m_hits == LOCK_N) begin m_mode = LOCK; m_misses = 0; end
        end else begin
          m_hits = 0;
          if (d != 0) m_ref = d; else m_mode = HUNT;
        end
      end else begin
        m_ref = expw;
        m_wc = m_wc + 1;
        if (d != expw) begin
          m_err = 1;
          if (m_ec != 16'hFFFF) m_ec = m_ec + 1;
          m_misses++;
          if (m_misses == LOSS_N) m_mode = HUNT;
        end else m_misses = 0;
      end
    end
    if (c) begin m_wc = 0; m_ec = 0; end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (run) begin
      if (locked !== (m_mode == LOCK)) begin
        miscompares++; $display("FAIL locked: got %b want %b t=%0t", locked, m_mode == LOCK, $time);
      end
      if (error !== m_err) begin
        miscompares++; $display("FAIL error: got %b want %b t=%0t", error, m_err, $time);
      end
      if (err_count !== m_ec) begin
        miscompares++; $display("FAIL err_count: got %0d want %0d t=%0t", err_count, m_ec, $time);
      end
      if (word_count !== m_wc) begin
        miscompares++; $display("FAIL word_count: got %0d want %0d t=%0t", word_count, m_wc, $time);
      end
      if (zero_seen !== m_zero) begin
        miscompares++; $display("FAIL zero_seen: got %b want %b t=%0t", zero_seen, m_zero, $time);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] want);
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic feed(input bit v, input logic [31:0] d, input bit c);
    in_valid = v; in_data = d; clear_counts = c;
    @(posedge clock);
    model_step(v, d, c);
    vectors++;
    #1;
  endtask

  task automatic async_reset();
    #1;
    reset = 1'b1; in_valid = 1'b0; clear_counts = 1'b0;
    model_reset();
    #1;
    lit("arst_locked", {31'd0, locked}, 0);
    lit("arst_error", {31'd0, error}, 0);
    lit("arst_err_count", {16'd0, err_count}, 0);
    lit("arst_word_count", word_count, 0);
    lit("arst_zero_seen", {31'd0, zero_seen}, 0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] g, d;
  bit v, c;
  int burst;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 0; clear_counts = 1'b0;
    model_reset();
    run = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    lit("rst_locked", {31'd0, locked}, 0);
    lit("rst_err_count", {16'd0, err_count}, 0);
    lit("rst_word_count", word_count, 0);
    reset = 1'b0;

    // Acquire on the canonical five-word stream.
    g = 32'h00FFFFFF;
    feed(1, g, 0);
    for (int i = 0; i < 4; i++) begin
      g = nxt(g);
      feed(1, g, 0);
      if (i == 2) lit("acq_not_yet", {31'd0, locked}, 0);
    end
    lit("acq_last_word", g, 32'h0FFFFFFF);
    lit("acq_locked", {31'd0, locked}, 1);
    lit("acq_err_count", {16'd0, err_count}, 0);

    // Single bit flip while locked.
    g = nxt(g);
    lit("flip_expected", g, 32'h1FFFFFFF);
    feed(1, g ^ 32'd1, 0);
    lit("flip_error", {31'd0, error}, 1);
    lit("flip_err_count", {16'd0, err_count}, 1);
    lit("flip_locked", {31'd0, locked}, 1);
    g = nxt(g);
    lit("after_flip_word", g, 32'h3FFFFFFF);
    feed(1, g, 0);
    lit("after_flip_error", {31'd0, error}, 0);
    lit("after_flip_wc", word_count, 2);

    // Clear, then lose lock on three consecutive corruptions, then re-lock.
    g = nxt(g);
    feed(1, g, 1);
    lit("clear_wc", word_count, 0);
    lit("clear_ec", {16'd0, err_count}, 0);
    for (int i = 0; i < 3; i++) begin
      g = nxt(g);
      feed(1, g ^ 32'h8000_0000, 0);
      lit("loss_error", {31'd0, error}, 1);
    end
    lit("loss_ec", {16'd0, err_count}, 3);
    lit("loss_locked", {31'd0, locked}, 0);
    for (int i = 0; i < 5; i++) begin
      g = nxt(g);
      feed(1, g, 0);
      if (i == 3) lit("relock_not_yet", {31'd0, locked}, 0);
    end
    lit("relock", {31'd0, locked}, 1);

    // Zero word in HUNT.
    async_reset();
    feed(1, 32'd0, 0);
    lit("zero_seen", {31'd0, zero_seen}, 1);
    lit("zero_locked", {31'd0, locked}, 0);
    g = 32'h00FFFFFF;
    feed(1, g, 0);
    for (int i = 0; i < 4; i++) begin g = nxt(g); feed(1, g, 0); end
    lit("zero_relock", {31'd0, locked}, 1);

    // Gapped valid while locked.
    g = nxt(g);
    feed(1, g, 1);
    lit("gap_clear", word_count, 0);
    for (int i = 0; i < 6; i++) begin
      feed(0, $urandom, 0);
      feed(0, $urandom, 0);
      g = nxt(g);
      feed(1, g, 0);
    end
    lit("gap_wc", word_count, 6);
    lit("gap_ec", {16'd0, err_count}, 0);
    g = nxt(g);
    feed(1, g, 1);
    lit("gap_clear2", word_count, 0);

    // Reach err_count=7 while staying locked, then reset asynchronously.
    for (int i = 0; i < 3; i++) begin
      g = nxt(g); feed(1, ~g, 0);
      g = nxt(g); feed(1, ~g, 0);
      g = nxt(g); feed(1, g, 0);
    end
    g = nxt(g); feed(1, ~g, 0);
    lit("seven_ec", {16'd0, err_count}, 7);
    lit("seven_locked", {31'd0, locked}, 1);
    async_reset();

    // Randomized traffic.
    burst = 0;
    g = 32'h1234_5678;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 999) < 3) async_reset();
      v = ($urandom_range(0, 3) != 0);
      c = v && ($urandom_range(0, 59) == 0);
      if (!v) d = $urandom;
      else if (burst > 0) begin
        g = nxt(g); d = g ^ (32'd1 << $urandom_range(0, 31)); burst--;
      end else begin
        int k;
        k = $urandom_range(0, 99);
        if (k < 2) d = 32'd0;
        else if (k < 5) begin g = $urandom; if (g == 0) g = 32'd1; d = g; end
        else if (k < 10) begin g = nxt(g); d = g ^ (32'd1 << $urandom_range(0, 31)); end
        else if (k < 12) begin burst = 2; g = nxt(g); d = ~g; end
        else begin g = nxt(g); d = g; end
      end
      feed(v, d, c);
    end

    in_valid = 1'b0;
    @(negedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
